// File: rtl/regfile_clr_bypass_pkg.sv
// regfile_clr_bypass_pkg: shared widths, register-0 index and clear FSM encoding
package regfile_clr_bypass_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO = 0;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;
endpackage

// File: rtl/regfile_clr_bypass_if.sv
// regfile_clr_bypass_if: register file access, clear handshake and debug read bundle
interface regfile_clr_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              WriteReg;
    logic [ADDR_W-1:0] WR;
    logic [DATA_W-1:0] WD;
    logic [ADDR_W-1:0] RR1;
    logic [DATA_W-1:0] RD1;
    logic [ADDR_W-1:0] RR2;
    logic [DATA_W-1:0] RD2;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] dbg_ra;
    logic [DATA_W-1:0] dbg_rd;
    modport master(
        output WriteReg, WR, WD, RR1, RR2, clr_req, dbg_ra,
        input  RD1, RD2, clr_busy, clr_done, dbg_rd
    );
    modport slave(
        input  WriteReg, WR, WD, RR1, RR2, clr_req, dbg_ra,
        output RD1, RD2, clr_busy, clr_done, dbg_rd
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: IDLE/CLEAR/DONE sequencer that walks every register address once
module regfile_clr_fsm
    import regfile_clr_bypass_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);
    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = state_q == CLEAR;
        clr_done = state_q == DONE;
        clr_en   = state_q == CLEAR;
        clr_addr = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = clr_req ? CLEAR : IDLE;
                cnt_d   = '0;
            end
            // last address is all ones, so exit before the counter wraps
            CLEAR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = &cnt_q ? DONE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/regfile_clr_bypass.sv
// regfile_clr_bypass: 2R1W register file with zero register, write bypass, bulk clear and debug port
module regfile_clr_bypass
    import regfile_clr_bypass_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic clk,
    input logic rst,
    regfile_clr_bypass_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              we_ok;
    regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_busy (bus.clr_busy),
        .clr_done (bus.clr_done),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );
    assign we_ok = bus.WriteReg && !bus.clr_busy && !(ZERO_REG != 0 && bus.WR == ADDR_W'(REG_ZERO));
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a, input logic byp);
        return (ZERO_REG != 0 && a == ADDR_W'(REG_ZERO)) ? '0 :
               (byp && BYPASS != 0 && we_ok && bus.WR == a) ? bus.WD : regs_q[a];
    endfunction
    always_comb begin
        regs_d = regs_q;
        if (clr_en) regs_d[clr_addr] = '0;
        if (we_ok) regs_d[bus.WR] = bus.WD;
        bus.RD1    = rd(bus.RR1, 1'b1);
        bus.RD2    = rd(bus.RR2, 1'b1);
        bus.dbg_rd = rd(bus.dbg_ra, 1'b0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end
endmodule

// File: tb/tb_regfile_clr_bypass.sv
// tb_regfile_clr_bypass: scoreboard bench for the bypassed and non-bypassed register file
module tb_regfile_clr_bypass;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    regfile_clr_bypass_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_clr_bypass_if #(.DATA_W(32), .ADDR_W(5)) nb ();
    regfile_clr_bypass #(.BYPASS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    regfile_clr_bypass #(.BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .bus(nb));
    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, o, e);
        end
    endtask
    function automatic logic [31:0] obs(input int p);
        case (p)
            0: return bus.RD1;
            1: return bus.RD2;
            2: return bus.dbg_rd;
            3: return {31'b0, bus.clr_busy};
            4: return {31'b0, bus.clr_done};
            5: return nb.RD1;
            default: return 'x;
        endcase
    endfunction
    task automatic push(input string tag, input int port, input logic [31:0] e);
        sbq.push_back('{tag, port, e});
    endtask
    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg,
                         input logic clr);
        bus.WriteReg = we; bus.WR = wr; bus.WD = wd; bus.RR1 = r1; bus.RR2 = r2;
        bus.dbg_ra = dbg; bus.clr_req = clr;
        nb.WriteReg = we; nb.WR = wr; nb.WD = wd; nb.RR1 = r1; nb.RR2 = r2;
        nb.dbg_ra = dbg; nb.clr_req = clr;
    endtask
    task automatic cyc();
        exp_t x;
        @(negedge clk);
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk(x.tag, obs(x.port), x.exp);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        int nbusy, ndone;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 5'(a), 5'(a), 5'(a), 0);
            push("rst_rd1", 0, 0); push("rst_rd2", 1, 0); push("rst_dbg", 2, 0);
            if (a == 0) begin push("rst_busy", 3, 0); push("rst_done", 4, 0); end
            cyc();
        end
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0); cyc();
        drive(1, 0, 32'h12345678, 0, 0, 0, 0); cyc();
        drive(0, 0, 0, 5, 0, 0, 0);
        push("wr_r5", 0, 32'hDEADBEEF); push("zero_rd2", 1, 0); push("zero_dbg", 2, 0);
        cyc();
        drive(1, 7, 32'hA5A5A5A5, 7, 5, 7, 0);
        push("byp_rd1", 0, 32'hA5A5A5A5); push("byp_rd2", 1, 32'hDEADBEEF);
        push("byp_dbg", 2, 0); push("nobyp_old", 5, 0);
        cyc();
        drive(1, 0, 32'hFFFFFFFF, 7, 0, 0, 0);
        push("after_byp", 0, 32'hA5A5A5A5); push("nobyp_new", 5, 32'hA5A5A5A5);
        push("byp_r0", 1, 0);
        cyc();
        for (int i = 1; i < 32; i++) begin
            drive(1, 5'(i), i, 0, 0, 0, 0); cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 1); cyc();
        for (int k = 0; k < 32; k++) begin
            drive(k == 1, 3, 32'hFFFF, k == 1 ? 5'd3 : (k == 10 ? 5'd20 : 5'd0),
                  k == 2 ? 5'd3 : (k == 10 ? 5'd5 : 5'd0), 0, 0);
            push("clr_busy", 3, 1); push("clr_nodone", 4, 0);
            if (k == 1) push("busy_nobyp", 0, 3);
            if (k == 2) push("busy_wr_drop", 1, 3);
            if (k == 10) begin push("busy_r20_live", 0, 20); push("busy_r5_clr", 1, 0); end
            cyc();
        end
        drive(1, 4, 32'h44, 0, 0, 0, 1);
        push("done_busy", 3, 0); push("done_pulse", 4, 1);
        cyc();
        drive(0, 0, 0, 4, 0, 0, 0);
        push("done_wr", 0, 32'h44); push("done_req_ign", 3, 0); push("done_once", 4, 0);
        cyc();
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 5'(a), 0, 5'(a), 0);
            push("clr_rd1", 0, a == 4 ? 32'h44 : 0); push("clr_dbg", 2, a == 4 ? 32'h44 : 0);
            cyc();
        end
        drive(1, 9, 32'h55, 0, 0, 0, 1); cyc();
        drive(0, 0, 0, 9, 0, 0, 0);
        push("sim_r9", 0, 32'h55); push("sim_busy", 3, 1);
        cyc();
        for (int k = 1; k < 32; k++) cyc();
        push("sim_done", 4, 1); cyc();
        push("sim_r9_clr", 0, 0); cyc();
        drive(1, 25, 32'h77, 0, 0, 0, 0); cyc();
        drive(0, 0, 0, 25, 0, 25, 1); cyc();
        drive(0, 0, 0, 25, 0, 25, 0);
        for (int k = 0; k < 12; k++) cyc();
        rst = 1'b1;
        #1;
        push("mid_rst_busy", 3, 0); push("mid_rst_done", 4, 0);
        push("mid_rst_rd1", 0, 0); push("mid_rst_dbg", 2, 0);
        cyc();
        rst = 1'b0;
        push("post_rst_busy", 3, 0); push("post_rst_done", 4, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 1); cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            nbusy += int'(bus.clr_busy);
            ndone += int'(bus.clr_done);
            @(posedge clk);
            #1;
        end
        chk("reclr_len", nbusy, 32);
        chk("reclr_done", ndone, 1);
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_clr_bypass.md
Name: regfile_clr_bypass

Overview:
Parametrised successor of the MIPS 32x32 register file. It has two combinational read ports and one synchronous write port. It adds an optional hard-wired zero register, optional write-to-read bypass, asynchronous reset of all registers, a sequential bulk-clear engine with a busy/done handshake, and a third debug read port. It sits in the datapath between the instruction decoder (register addresses) and the ALU/writeback mux.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1, a write accepted this cycle is forwarded to any read port addressing the same register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- WriteReg  in  1  write enable.
- WR  in  ADDR_W  write address.
- WD  in  DATA_W  write data.
- RR1  in  ADDR_W  read address, port 1.
- RD1  out  DATA_W  read data, port 1 (combinational).
- RR2  in  ADDR_W  read address, port 2.
- RD2  out  DATA_W  read data, port 2 (combinational).
- clr_req  in  1  request a bulk clear of all registers.
- clr_busy  out  1  high while the clear engine is running.
- clr_done  out  1  one-cycle pulse when the clear completes.
- dbg_ra  in  ADDR_W  debug read address.
- dbg_rd  out  DATA_W  debug read data (combinational, never bypassed).

Behaviour:
- Reset (rst=1, asynchronous): all NREG registers go to 0; FSM goes to IDLE; clear counter goes to 0; clr_busy=0; clr_done=0. Reset asserted mid-clear aborts the clear. There is no clr_done pulse; registers are 0 from the reset itself.
- Write acceptance: we_ok = WriteReg & ~clr_busy & ~(ZERO_REG & WR==0).
  - If we_ok, reg[WR] <= WD at the rising edge of clk.
  - Writes while clr_busy=1 are dropped silently.
- Read ports 1 and 2 are evaluated in priority order:
  - ZERO_REG and RRx==0 -> 0.
  - Else BYPASS and we_ok and WR==RRx -> WD.
  - Else reg[RRx].
  - Zero latency in all cases.
- BYPASS=0: a read of the address being written returns the old value. The new value is visible from the next cycle.
- Debug port: dbg_rd = reg[dbg_ra]. ZERO_REG forcing still applies; bypass does not.
- Clear FSM states are IDLE, CLEAR and DONE.
- IDLE:
  - clr_busy=0, clr_done=0.
  - clr_req=1 at a clock edge -> CLEAR, cnt<=0.
  - A write accepted in the same cycle as clr_req commits, then gets cleared.
- CLEAR:
  - clr_busy=1; each cycle reg[cnt] <= 0 and cnt <= cnt+1.
  - When cnt==NREG-1 the state goes to DONE. The clear occupies exactly NREG cycles.
  - The counter is ADDR_W wide; wrap-around is never reached because the exit happens at NREG-1.
  - clr_req is ignored in this state.
  - Reads return live contents: already-cleared registers read 0, the others keep their old values.
- DONE:
  - clr_busy=0, clr_done=1 for exactly one cycle, then -> IDLE.
  - Writes are accepted in DONE.
  - clr_req in DONE is ignored; it must be re-asserted while in IDLE.
- Request-to-done latency: clr_req sampled at edge N -> clr_busy high from N to N+NREG -> clr_done high in cycle N+NREG to N+NREG+1.
- All outputs are free of X after reset. Register contents are never X.

Decomposition:
- Shared package/include (mips_defs): DATA_W and ADDR_W defaults, register-0 index constant, FSM state encodings (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2).
- One natural sub-module, regfile_clr_fsm: the IDLE/CLEAR/DONE machine plus counter. It outputs clr_busy, clr_done, clr_en and clr_addr.
- The storage array, write decode and read muxing stay in the top level as behavioural arrays. The old structural dff and 32-input mux instances are not reused.

Test Plan:
- Reset then read: rst pulse; read all addresses on RR1, RR2 and dbg_ra -> every read is 0; clr_busy=0, clr_done=0.
- Write/read and zero register (ZERO_REG=1): write 0xDEADBEEF to r5, then 0x12345678 to r0; next cycle RR1=5, RR2=0 -> RD1=0xDEADBEEF, RD2=0.
- Bypass (BYPASS=1): WriteReg=1, WR=7, WD=0xA5A5A5A5, RR1=7 in the same cycle -> RD1=0xA5A5A5A5 that cycle, while dbg_ra=7 returns the old value 0. With BYPASS=0 -> RD1 is the old value 0, and 0xA5A5A5A5 appears the next cycle.
- Bulk clear: fill r1..r31 with their own index; pulse clr_req.
  - clr_busy is high for 32 cycles; clr_done pulses 1 cycle.
  - A write of 0xFFFF to r3 during busy is dropped.
  - All reads are 0 afterwards.
  - At busy cycle 10, r20 still reads 20.
- Simultaneous write and clr_req in IDLE: write 0x55 to r9 together with clr_req -> r9 reads 0x55 for one cycle, then reads 0 after done.
- Reset mid-clear: assert rst at busy cycle 12 -> clr_busy=0 immediately, no clr_done pulse, all registers read 0. A subsequent clr_req starts a full 32-cycle clear.
